rs_erasure_corrector: RTL

RS_ERASURE_CORRECTOR -- requirements
Module: rs_erasure_corrector

---
 rtl/rs_erasure_corrector.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_erasure_corrector.sv
// Shortened Reed-Solomon erasure/error corrector over GF(2^8) (poly 0x11D,
// alpha = 0x02). The codeword has 8 data symbols plus two parities: P0, the
// plain sum, and P1, the alpha^k-weighted sum. The block takes the received
// word, its two syndromes and an erasure mask. It repairs up to two erased
// symbols, or one unflagged symbol error when nothing is erased.
// The latency is a fixed nine cycles: one analysis cycle, seven cycles of
// inversion by exponentiation (X^254), and one correction cycle.
module rs_erasure_corrector (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [79:0] codeword_in,
  input  logic [15:0] syndrome_in,
  input  logic [9:0]  erasure_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic [1:0]  status_out
);

  typedef enum logic [2:0] {IDLE, ANALYZE, INV, CORRECT, OUT} state_t;

  // Decoding case chosen in ANALYZE and consumed in CORRECT.
  typedef enum logic [3:0] {
    C_NONE,   // no erasures: syndrome-driven single-error correction
    C_D1,     // one data symbol erased
    C_P0,     // only P0 erased
    C_P1,     // only P1 erased
    C_DD,     // two data symbols erased
    C_P0D,    // P0 and one data symbol erased
    C_P1D,    // P1 and one data symbol erased
    C_P0P1,   // both parities erased, data trusted
    C_DUE     // more than two erasures
  } case_t;

  localparam logic [1:0] ST_NE  = 2'b00;
  localparam logic [1:0] ST_CE  = 2'b01;
  localparam logic [1:0] ST_DUE = 2'b10;

  // GF(2^8) multiply, shift-and-add with reduction by x^8 = x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc ^= sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  // alpha^k for k < 8 never wraps the field, so it is simply a one-hot byte.
  function automatic logic [7:0] alpha_pow(input logic [2:0] k);
    return 8'h01 << k;
  endfunction

  // Place a symbol value at data position k using the codeword packing
  // (symbol 0 in the most significant byte).
  function automatic logic [63:0] at_sym(input logic [7:0] v, input logic [2:0] k);
    logic [5:0] sh;
    sh = {3'd7 - k, 3'b000};
    return {56'd0, v} << sh;
  endfunction

  state_t      state;
  state_t      state_next;

  logic [79:0] cw_q;
  logic [15:0] syn_q;
  logic [9:0]  era_q;

  case_t       case_q;
  logic [2:0]  pos_i_q;
  logic [2:0]  pos_j_q;
  logic [7:0]  x_q;
  logic [7:0]  inv_acc;
  logic [2:0]  inv_cnt;

  logic [7:0]  s0;
  logic [7:0]  s1;
  assign s0 = syn_q[15:8];
  assign s1 = syn_q[7:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so that all registers
    // sample the pre-edge values and simulation matches the synthesised flops.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default comes first so every path assigns state_next and
    // no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)          state_next = ANALYZE;
      ANALYZE:                        state_next = INV;
      INV:     if (inv_cnt == 3'd6)   state_next = CORRECT;
      CORRECT:                        state_next = OUT;
      OUT:     if (out_ready)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Capture the input bundle on the IDLE handshake.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers are deliberately not reset. They are
    // always written before they are read, and the FSM reset alone discards
    // any in-flight bundle.
    if (state == IDLE && in_valid) begin
      cw_q  <= codeword_in;
      syn_q <= syndrome_in;
      era_q <= erasure_in;
    end
  end

  // ANALYZE: classify the erasure pattern and pick the operand to invert.
  logic [3:0] era_cnt;
  logic [2:0] pos_lo;
  logic [2:0] pos_hi;
  case_t      an_case;
  logic [7:0] an_x;

  always_comb begin
    era_cnt = '0;
    pos_lo  = '0;
    pos_hi  = '0;
    for (int k = 0; k < 10; k++) era_cnt += {3'b000, era_q[k]};
    for (int k = 7; k >= 0; k--) if (era_q[k]) pos_lo = 3'(k);
    for (int k = 0; k < 8; k++)  if (era_q[k]) pos_hi = 3'(k);

    an_case = C_DUE;
    an_x    = 8'h01;
    case (era_cnt)
      4'd0: begin
        an_case = C_NONE;
        an_x    = s0;
      end
      4'd1: begin
        if (era_q[8])      an_case = C_P0;
        else if (era_q[9]) an_case = C_P1;
        else               an_case = C_D1;
      end
      4'd2: begin
        if (era_q[8] && era_q[9]) begin
          an_case = C_P0P1;
        end else if (era_q[8]) begin
          an_case = C_P0D;
          an_x    = alpha_pow(pos_hi);
        end else if (era_q[9]) begin
          an_case = C_P1D;
        end else begin
          an_case = C_DD;
          an_x    = alpha_pow(pos_lo) ^ alpha_pow(pos_hi);
        end
      end
      default: an_case = C_DUE;
    endcase
  end

  // Latch the ANALYZE decision and seed the inversion accumulator with X.
  always_ff @(posedge clk) begin
    if (state == ANALYZE) begin
      case_q  <= an_case;
      pos_i_q <= pos_lo;
      pos_j_q <= pos_hi;
      x_q     <= an_x;
    end
  end

  // INV: acc <- acc^2 * X for six cycles, then acc <- acc^2 on the seventh.
  // The exponent runs 1,3,7,...,127 and then 254, so acc ends at X^-1.
  // An input of 0 stays 0.
  logic [7:0] inv_sq;
  assign inv_sq = gf_mul(inv_acc, inv_acc);

  // Inversion counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_cnt <= '0;
    end else if (state == INV) begin
      inv_cnt <= inv_cnt + 3'd1;
    end else begin
      inv_cnt <= '0;
    end

    if (state == ANALYZE) inv_acc <= an_x;
    else if (state == INV) inv_acc <= (inv_cnt == 3'd6) ? inv_sq : gf_mul(inv_sq, x_q);
  end

  // CORRECT: error values and the resulting status.
  logic [7:0]  prod_s1_inv;   // S1/S0 (no erasures) or S1*alpha^-j (P0 + data)
  logic [7:0]  prod_s0_aj;    // S0 * alpha^j
  logic [7:0]  e_i;           // lower erased data error (two data erasures)
  logic [63:0] err_pat;
  logic [1:0]  corr_status;
  logic        syn_nz;

  assign prod_s1_inv = gf_mul(s1, inv_acc);
  assign prod_s0_aj  = gf_mul(s0, alpha_pow(pos_j_q));
  assign e_i         = gf_mul(s1 ^ prod_s0_aj, inv_acc);
  // In every non-DUE erasure case the erased symbols account for the whole
  // syndrome. An error value is therefore nonzero exactly when the syndrome
  // is nonzero.
  assign syn_nz      = |syn_q;

  // Build the data error pattern and status for the latched case.
  always_comb begin
    err_pat     = '0;
    corr_status = ST_NE;
    unique case (case_q)
      C_NONE: begin
        if (!syn_nz) begin
          corr_status = ST_NE;
        end else if (s0 == 8'h00 || s1 == 8'h00) begin
          corr_status = ST_CE;   // a lone parity symbol is wrong
        end else if (prod_s1_inv != 8'h00 &&
                     (prod_s1_inv & (prod_s1_inv - 8'h01)) == 8'h00) begin
          // S1/S0 = alpha^j with j < 8 is one-hot; its set bit is the position.
          for (int k = 0; k < 8; k++)
            if (prod_s1_inv[k]) err_pat = err_pat | at_sym(s0, 3'(k));
          corr_status = ST_CE;
        end else begin
          corr_status = ST_DUE;
        end
      end
      C_D1: begin
        if (s1 != prod_s0_aj) begin
          corr_status = ST_DUE;
        end else begin
          err_pat     = at_sym(s0, pos_j_q);
          corr_status = syn_nz ? ST_CE : ST_NE;
        end
      end
      C_P0:   corr_status = (s1 != 8'h00) ? ST_DUE : (syn_nz ? ST_CE : ST_NE);
      C_P1:   corr_status = (s0 != 8'h00) ? ST_DUE : (syn_nz ? ST_CE : ST_NE);
      C_DD: begin
        err_pat     = at_sym(e_i, pos_i_q) | at_sym(e_i ^ s0, pos_j_q);
        corr_status = syn_nz ? ST_CE : ST_NE;
      end
      C_P0D: begin
        err_pat     = at_sym(prod_s1_inv, pos_j_q);
        corr_status = syn_nz ? ST_CE : ST_NE;
      end
      C_P1D: begin
        err_pat     = at_sym(s0, pos_j_q);
        corr_status = syn_nz ? ST_CE : ST_NE;
      end
      C_P0P1: corr_status = syn_nz ? ST_CE : ST_NE;
      default: corr_status = ST_DUE;
    endcase
  end

  // Output registers: loaded in CORRECT and held through OUT.
  // A DUE result passes the received data through untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      status_out <= ST_NE;
    end else if (state == CORRECT) begin
      data_out   <= (corr_status == ST_DUE) ? cw_q[79:16] : (cw_q[79:16] ^ err_pat);
      status_out <= corr_status;
    end
  end

endmodule
